// File: rtl/cla_adder.sv
// 4-bit carry-lookahead adder with a registered sum and a combinational carry out.
// c_out is a pure function of A, B and c_in, so adders can be chained within one cycle.
module cla_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       c_in,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Output,
  output logic       c_out,
  output logic       ready
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat sum of products of g, p and c_in; no carry feeds another.
  assign c[0] = c_in;
  assign c[1] = g[0]
              | (p[0] & c_in);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_in);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output <= 4'h0;
      ready  <= 1'b0;
    end else begin
      ready <= en;
      if (en) begin
        Output <= s;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Directed and exhaustive checks for cla_adder: vector table, reset corner cases, full sweep.
module tb_cla_adder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       c_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Output;
  logic       c_out;
  logic       ready;

  int checks = 0;
  int errors = 0;

  cla_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .c_in   (c_in),
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       en;
    logic [3:0] exp_out;
    logic       exp_ready;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive between edges, check c_out before the edge, then registered outputs after it.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic e,
                       input logic [3:0] exp_out, input logic exp_rdy, input logic exp_co,
                       input string name);
    @(negedge clk);
    A = a; B = b; c_in = cin; en = e;
    #1;
    check({name, " c_out"}, {7'd0, c_out}, {7'd0, exp_co});
    @(posedge clk);
    #1;
    check({name, " Output"}, {4'd0, Output}, {4'd0, exp_out});
    check({name, " ready"}, {7'd0, ready}, {7'd0, exp_rdy});
  endtask

  initial begin
    vecs[0] = '{4'h3, 4'h4, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0};
    vecs[1] = '{4'h1, 4'h1, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1};
    vecs[3] = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
    vecs[4] = '{4'h9, 4'hA, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1};
    vecs[5] = '{4'h7, 4'h7, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[6] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1};
    vecs[7] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[8] = '{4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1};

    rst_n = 1'b0; en = 1'b0; c_in = 1'b0; A = 4'h0; B = 4'h0;
    #2;
    check("reset Output", {4'd0, Output}, 8'h00);
    check("reset ready", {7'd0, ready}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].en,
            vecs[i].exp_out, vecs[i].exp_ready, vecs[i].exp_cout, $sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while holding a valid result of 9.
    apply(4'h4, 4'h5, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, "pre-reset");
    #2;
    A = 4'hF; B = 4'h1; c_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset Output", {4'd0, Output}, 8'h00);
    check("async reset ready", {7'd0, ready}, 8'h00);
    check("c_out live in reset", {7'd0, c_out}, 8'h01);
    @(posedge clk);
    #1;
    check("reset held Output", {4'd0, Output}, 8'h00);
    check("reset held ready", {7'd0, ready}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'h6, 4'h5, 1'b1, 1'b1, 4'hC, 1'b1, 1'b0, "post-reset first");

    // Exhaustive sweep with en held high; expected value from plain integer addition.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] sum;
          sum = 5'(a) + 5'(b) + 5'(ci);
          apply(4'(a), 4'(b), 1'(ci), 1'b1, sum[3:0], 1'b1, sum[4],
                $sformatf("sweep %0d+%0d+%0d", a, b, ci));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en  input  1  compute enable, sampled at the rising edge of clk.
REQ-005 c_in  input  1  carry into bit 0.
REQ-006 A  input  4  operand A, unsigned.
REQ-007 B  input  4  operand B, unsigned; the caller applies any subtract inversion before this port.
REQ-008 Output  output  4  registered sum bits.
REQ-009 c_out  output  1  combinational carry out of bit 3 for the current A, B and c_in.
REQ-010 ready  output  1  registered flag: Output holds a result captured at the last edge.

Function
REQ-011 Per-bit terms SHALL be generate g[i]=A[i]&B[i] and propagate p[i]=A[i]^B[i], for i=0..3.
REQ-012 Carries SHALL be computed by lookahead, not by ripple:
- c1=g0|p0&c_in
- c2=g1|p1&g0|p1&p0&c_in
- c3 and c4 expanded in the same flattened sum-of-products form
REQ-013 Sum bits SHALL be s[i]=p[i]^c[i], with c[0]=c_in.
REQ-014 c_out SHALL equal c4 combinationally, with no clock latency, so that two instances can be chained c_out-to-c_in within one cycle.
REQ-015 At a rising edge with en=1, Output SHALL load s[3:0], i.e. (A+B+c_in) mod 16, and ready SHALL load 1.
REQ-016 At a rising edge with en=0, Output SHALL hold its value and ready SHALL load 0.
REQ-017 Latency SHALL be one cycle: the result is visible on Output, with ready=1, after the edge that sampled en=1.
REQ-018 With en held at 1 and inputs changing every cycle, Output SHALL update every cycle (full throughput) and ready SHALL stay 1.
REQ-019 Overflow SHALL wrap: Output is the low 4 bits and the carry appears only on c_out; there is no saturation and no signed overflow flag.
REQ-020 X-free inputs SHALL produce X-free outputs; there is no internal state other than Output and ready.

Reset
REQ-021 While rst_n=0, Output SHALL be 4'h0 and ready SHALL be 0, immediately and independently of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result.
REQ-023 c_out SHALL remain a live combinational function of its inputs during reset.
REQ-024 After rst_n deasserts, the first edge with en=1 SHALL produce a valid result with ready=1.

Verification
REQ-025 Reset: assert rst_n=0 between edges with ready=1 and Output=4'h9 -> Output=0 and ready=0 immediately, before the next edge.
REQ-026 Basic add: A=3, B=4, c_in=0, en=1, then one edge -> Output=7, ready=1; c_out=0 throughout.
REQ-027 Overflow: A=4'hF, B=4'h1, c_in=0 -> c_out=1 before any edge; after an en=1 edge, Output=0 and ready=1.
REQ-028 Full carry chain: A=4'hF, B=4'h0, c_in=1 -> c_out=1 and, after an en=1 edge, Output=0. Subtract case: A=9, B=~5=4'hA, c_in=1 -> Output=4, c_out=1.
REQ-029 Enable low: after capturing Output=7, drive en=0 and A=1, B=1 -> Output stays 7 and ready=0 after the next edge.
REQ-030 Exhaustive: sweep all 512 combinations of A, B and c_in with en=1 -> every edge gives {c_out_sampled, Output} = A+B+c_in, and ready stays 1.
